// File: rtl/dmem_dma_arbiter_pkg.sv
// dmem_arb_pkg: shared defaults and engine state encoding for the DMem/DMA arbiter.
package dmem_arb_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int STARVE_LIM_DEF = 4;
    typedef logic [1:0] dma_state_t;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD = 2'd1;
    localparam logic [1:0] WR = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/dmem_dma_arbiter_if.sv
// dmem_dma_arbiter_if: core, copy-engine control and DMem port signals of the arbiter.
interface dmem_dma_arbiter_if import dmem_arb_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic core_req;
    logic core_wen;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdat;
    logic [DW-1:0] core_rdat;
    logic core_stall;
    logic dma_start;
    logic [AW-1:0] dma_src;
    logic [AW-1:0] dma_dst;
    logic [AW-1:0] dma_len;
    logic dma_busy;
    logic dma_done;
    logic mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic [DW-1:0] mem_rdat;
    modport slave (
        input core_req, core_wen, core_addr, core_wdat,
        input dma_start, dma_src, dma_dst, dma_len, mem_rdat,
        output core_rdat, core_stall, dma_busy, dma_done, mem_wen, mem_addr, mem_wdat
    );
    modport master (
        output core_req, core_wen, core_addr, core_wdat,
        output dma_start, dma_src, dma_dst, dma_len, mem_rdat,
        input core_rdat, core_stall, dma_busy, dma_done, mem_wen, mem_addr, mem_wdat
    );
endinterface

// File: rtl/dmem_dma_arbiter_starve.sv
// arb_starve_counter: counts consecutive blocked engine cycles and forces one grant at LIM.
module arb_starve_counter import dmem_arb_pkg::*; #(
    parameter int LIM = STARVE_LIM_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic blocked,
    input  logic granted,
    input  logic clear,
    output logic force_grant
);
    localparam int CW = $clog2(LIM + 1);
    logic [CW-1:0] wait_cnt;
    always_ff @(posedge Clk) begin
        if (Reset || clear || granted) wait_cnt <= '0;
        else if (blocked && wait_cnt != CW'(LIM)) wait_cnt <= wait_cnt + 1'b1;
    end
    assign force_grant = wait_cnt == CW'(LIM);
endmodule

// File: rtl/dmem_dma_arbiter.sv
// dmem_dma_arbiter: shares the DMem port between the core and a forward block-copy engine,
// core first, with a starvation guard that periodically forces one engine access.
module dmem_dma_arbiter import dmem_arb_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input logic Clk,
    input logic Reset,
    dmem_dma_arbiter_if.slave bus
);
    dma_state_t state, next_state;
    logic [AW-1:0] src, dst, idx, remaining;
    logic [DW-1:0] buffer;
    logic active, force_grant, eng_grant, blocked;

    arb_starve_counter #(.LIM(STARVE_LIM)) u_starve (
        .Clk(Clk),
        .Reset(Reset),
        .blocked(blocked),
        .granted(eng_grant),
        .clear(state == IDLE),
        .force_grant(force_grant)
    );

    always_comb begin
        active = state == RD || state == WR;
        eng_grant = active && (!bus.core_req || force_grant);
        blocked = active && bus.core_req && !force_grant;
        bus.core_stall = active && bus.core_req && force_grant;
        bus.core_rdat = bus.mem_rdat;
        bus.dma_busy = active;
        bus.dma_done = state == DONE;
        bus.mem_addr = eng_grant ? (state == WR ? dst + idx : src + idx) : bus.core_addr;
        bus.mem_wdat = eng_grant ? buffer : bus.core_wdat;
        // Reset suppresses the write in the same cycle so an aborted copy leaves no trace.
        bus.mem_wen = !Reset && (eng_grant ? state == WR : bus.core_wen && bus.core_req);
        next_state = state == IDLE ? (bus.dma_start ? (bus.dma_len != '0 ? RD : DONE) : IDLE)
                   : state == RD   ? (eng_grant ? WR : RD)
                   : state == WR   ? (eng_grant ? (remaining > 1 ? RD : DONE) : WR)
                   : IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            src <= '0;
            dst <= '0;
            idx <= '0;
            remaining <= '0;
            buffer <= '0;
        end else begin
            if (state == IDLE && bus.dma_start) begin
                src <= bus.dma_src;
                dst <= bus.dma_dst;
                idx <= '0;
                remaining <= bus.dma_len;
            end
            if (state == RD && eng_grant) buffer <= bus.mem_rdat;
            if (state == WR && eng_grant) begin
                idx <= idx + 1'b1;
                remaining <= remaining - 1'b1;
            end
            state <= next_state;
        end
    end
endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// tb_dmem_dma_arbiter: directed and randomized copies against a byte-array reference image.
module tb_dmem_dma_arbiter;
    logic Clk = 0;
    logic Reset;
    always #5 Clk = ~Clk;

    dmem_dma_arbiter_if #(.AW(8), .DW(8)) bus ();
    dmem_dma_arbiter #(.AW(8), .DW(8), .STARVE_LIM(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    int checks = 0;
    int errors = 0;

    assign bus.mem_rdat = mem[bus.mem_addr];
    always @(posedge Clk) if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] pick_free(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        logic [7:0] a;
        logic [7:0] ds;
        logic [7:0] dd;
        a = 8'($urandom);
        for (int k = 0; k < 10000; k++) begin
            ds = a - s;
            dd = a - d;
            if (ds >= n && dd >= n) break;
            a = 8'($urandom);
        end
        return a;
    endfunction

    task automatic compare_mem(input string tag);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        chk({tag, " bad bytes"}, bad, 0);
        if (bad != 0) $display("  %s first differing address %0h", tag, first);
    endtask

    // mode 0: core idle, 1: core requests every cycle, 2: random core traffic.
    // Core stores stay outside both copy windows, so the final image is order independent.
    task automatic run_copy(input string tag, input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                            input int mode, input int inj, output int done_cyc);
        logic creq, cwen, pend;
        logic [7:0] ca, cd;
        for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
        for (int i = 0; i < n; i++) exp_mem[8'(d + 8'(i))] = exp_mem[8'(s + 8'(i))];
        @(posedge Clk); #1;
        bus.dma_start = 1;
        bus.dma_src = s;
        bus.dma_dst = d;
        bus.dma_len = n;
        bus.core_req = 0;
        done_cyc = -1;
        pend = 0;
        creq = 0;
        cwen = 0;
        ca = 0;
        cd = 0;
        for (int cyc = 1; cyc <= 4000 && done_cyc < 0; cyc++) begin
            @(posedge Clk); #1;
            bus.dma_start = cyc == inj;
            bus.dma_src = 8'($urandom);
            bus.dma_dst = 8'($urandom);
            bus.dma_len = 8'($urandom);
            if (!pend) begin
                creq = mode == 1 || (mode == 2 && $urandom_range(1) == 1);
                cwen = $urandom_range(1) == 1;
                ca = pick_free(s, d, n);
                cd = 8'($urandom);
            end
            bus.core_req = creq;
            bus.core_wen = cwen;
            bus.core_addr = ca;
            bus.core_wdat = cd;
            @(negedge Clk);
            if (creq && !bus.core_stall && !cwen) chk({tag, " core read"}, bus.core_rdat, exp_mem[ca]);
            if (mode == 0) begin
                chk({tag, " busy"}, bus.dma_busy, cyc <= 2 * n);
                chk({tag, " engine wen"}, bus.mem_wen, cyc % 2 == 0 && cyc <= 2 * n);
            end
            if (mode == 1) chk({tag, " stall"}, bus.core_stall, cyc % 5 == 0 && cyc <= 10 * n);
            if (creq && !bus.core_stall && cwen) exp_mem[ca] = cd;
            pend = creq && bus.core_stall;
            if (bus.dma_done) done_cyc = cyc;
        end
        @(posedge Clk); #1;
        bus.core_req = 0;
        bus.dma_start = 0;
        compare_mem(tag);
        @(negedge Clk);
        chk({tag, " done single pulse"}, bus.dma_done, 0);
    endtask

    initial begin
        int d;
        logic [7:0] s, t, n;
        #900000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        logic [7:0] s, t, n;
        Reset = 1;
        bus.core_req = 1;
        bus.core_wen = 1;
        bus.core_addr = 8'h05;
        bus.core_wdat = 8'hAA;
        bus.dma_start = 0;
        bus.dma_src = 0;
        bus.dma_dst = 0;
        bus.dma_len = 0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset mem_wen", bus.mem_wen, 0);
        chk("reset busy", bus.dma_busy, 0);
        chk("reset done", bus.dma_done, 0);
        chk("reset stall", bus.core_stall, 0);
        @(posedge Clk); #1;
        Reset = 0;
        bus.core_req = 0;
        bus.core_wen = 0;

        run_copy("basic", 8'h10, 8'h80, 8'd4, 0, 0, d);
        chk("basic done cycle", d, 9);
        run_copy("len0", 8'h20, 8'h30, 8'd0, 0, 0, d);
        chk("len0 done cycle", d, 1);
        run_copy("starve", 8'h20, 8'h60, 8'd2, 1, 0, d);
        chk("starve done cycle", d, 21);
        run_copy("wrap", 8'hFE, 8'h40, 8'd4, 0, 0, d);
        chk("wrap done cycle", d, 9);
        run_copy("restart ignored", 8'h30, 8'h90, 8'd3, 0, 3, d);
        chk("restart done cycle", d, 7);
        run_copy("overlap", 8'h50, 8'h52, 8'd6, 0, 0, d);
        chk("overlap done cycle", d, 13);

        // Abort in the second byte's write cycle: only byte 0 may land.
        for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
        exp_mem[8'hC0] = exp_mem[8'hA0];
        @(posedge Clk); #1;
        bus.dma_start = 1;
        bus.dma_src = 8'hA0;
        bus.dma_dst = 8'hC0;
        bus.dma_len = 8'd5;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge Clk); #1;
            bus.dma_start = 0;
        end
        @(posedge Clk); #1;
        Reset = 1;
        @(negedge Clk);
        chk("abort wen", bus.mem_wen, 0);
        @(posedge Clk); #1;
        Reset = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge Clk);
            chk("abort busy", bus.dma_busy, 0);
            chk("abort done", bus.dma_done, 0);
            @(posedge Clk); #1;
        end
        compare_mem("abort");
        run_copy("after abort", 8'hA0, 8'hC0, 8'd5, 0, 0, d);
        chk("after abort done cycle", d, 11);

        for (int r = 0; r < 8; r++) begin
            s = 8'($urandom);
            t = 8'($urandom);
            n = 8'($urandom_range(20, 1));
            run_copy("random", s, t, n, r % 2 == 0 ? 2 : 0, 0, d);
            if (r % 2 == 0) chk("random done window", d >= 2 * n + 1 && d <= 10 * n + 1, 1);
            else chk("random done cycle", d, 2 * n + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
